// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode constants and the decoded-instruction bundle
// used by the decode stage and its field decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [4:0] REG_RA   = 5'd31;

    // Everything the execute-side handlers need from one instruction word.
    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm16;
        logic [31:0] imm_ext;
        logic [25:0] jtarget;
        logic [4:0]  dest;
        logic        reg_write;
        logic        is_lui;
        logic        illegal;
    } decoded_t;

endpackage

// File: rtl/instr_field_decoder.sv
// instr_field_decoder: purely combinational split of a MIPS word into
// fields, immediate extension and destination/write-enable selection.
// With DECODE_ILLEGAL_TRAP_EN defined, unsupported opcodes raise illegal.
module instr_field_decoder
    import mips_pkg::*;
(
    input  logic [31:0] i_instr,
    output decoded_t    o_dec
);

    logic [15:0] w_imm16;
    logic [31:0] w_signExt;
    logic [31:0] w_zeroExt;
    logic        w_writes;

    assign w_imm16   = i_instr[15:0];
    assign w_signExt = {{16{w_imm16[15]}}, w_imm16};
    assign w_zeroExt = {16'h0000, w_imm16};

    // Raw fields always pass through; opcode selects extension, destination and write intent.
    always_comb begin
        o_dec         = '0;
        w_writes      = 1'b0;
        o_dec.opcode  = i_instr[31:26];
        o_dec.rs      = i_instr[25:21];
        o_dec.rt      = i_instr[20:16];
        o_dec.rd      = i_instr[15:11];
        o_dec.shamt   = i_instr[10:6];
        o_dec.funct   = i_instr[5:0];
        o_dec.imm16   = w_imm16;
        o_dec.jtarget = i_instr[25:0];
        o_dec.is_lui  = (i_instr[31:26] == OP_LUI);
        case (i_instr[31:26])
            OP_RTYPE: begin
                o_dec.dest = i_instr[15:11];
                w_writes   = 1'b1;
            end
            OP_J: begin
                o_dec.dest = 5'd0;
            end
            OP_JAL: begin
                o_dec.dest = REG_RA;
                w_writes   = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_SW: begin
                o_dec.imm_ext = w_signExt;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_LW: begin
                o_dec.imm_ext = w_signExt;
                o_dec.dest    = i_instr[20:16];
                w_writes      = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                o_dec.imm_ext = w_zeroExt;
                o_dec.dest    = i_instr[20:16];
                w_writes      = 1'b1;
            end
            OP_LUI: begin
                o_dec.imm_ext = {w_imm16, 16'h0000};
                o_dec.dest    = i_instr[20:16];
                w_writes      = 1'b1;
            end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                o_dec.illegal = 1'b1;
`endif
            end
        endcase
        // Writes to $zero are suppressed so downstream never sees a dead write.
        o_dec.reg_write = w_writes && (o_dec.dest != 5'd0);
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes fetched MIPS words and holds them in a 2-entry
// skid buffer (main + skid) so in_ready is a register yet throughput is
// one per cycle. Optional illegal-opcode trap: DECODE_ILLEGAL_TRAP_EN.
module decode_stage
    import mips_pkg::*;
#(
    parameter int PC_W = 32
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [5:0]      out_opcode,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_shamt,
    output logic [5:0]      out_funct,
    output logic [15:0]     out_imm16,
    output logic [31:0]     out_imm_ext,
    output logic [25:0]     out_jtarget,
    output logic [4:0]      out_dest,
    output logic            out_reg_write,
    output logic            out_is_lui,
    output logic            out_illegal
);

    decoded_t        w_dec;
    logic            w_inFire;
    logic            w_mainFree;

    decoded_t        r_main;
    logic [PC_W-1:0] r_mainPc;
    logic            r_mainValid;
    decoded_t        r_skid;
    logic [PC_W-1:0] r_skidPc;
    logic            r_skidValid;

    instr_field_decoder u_decoder (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    // in_ready comes straight from the skid-valid flop, so it is registered.
    assign in_ready   = !r_skidValid;
    assign w_inFire   = in_valid && in_ready;
    assign w_mainFree = !r_mainValid || out_ready;

    // Buffer update: flush wins, then refill main from skid first to keep order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main      <= '0;
            r_mainPc    <= '0;
            r_mainValid <= 1'b0;
            r_skid      <= '0;
            r_skidPc    <= '0;
            r_skidValid <= 1'b0;
        end else if (flush) begin
            r_main      <= '0;
            r_mainPc    <= '0;
            r_mainValid <= 1'b0;
            r_skid      <= '0;
            r_skidPc    <= '0;
            r_skidValid <= 1'b0;
        end else if (w_mainFree) begin
            if (r_skidValid) begin
                r_main      <= r_skid;
                r_mainPc    <= r_skidPc;
                r_mainValid <= 1'b1;
                r_skidValid <= 1'b0;
            end else if (w_inFire) begin
                r_main      <= w_dec;
                r_mainPc    <= in_pc;
                r_mainValid <= 1'b1;
            end else begin
                r_mainValid <= 1'b0;
            end
        end else if (w_inFire) begin
            r_skid      <= w_dec;
            r_skidPc    <= in_pc;
            r_skidValid <= 1'b1;
        end
    end

    assign out_valid     = r_mainValid;
    assign out_pc        = r_mainPc;
    assign out_opcode    = r_main.opcode;
    assign out_rs        = r_main.rs;
    assign out_rt        = r_main.rt;
    assign out_rd        = r_main.rd;
    assign out_shamt     = r_main.shamt;
    assign out_funct     = r_main.funct;
    assign out_imm16     = r_main.imm16;
    assign out_imm_ext   = r_main.imm_ext;
    assign out_jtarget   = r_main.jtarget;
    assign out_dest      = r_main.dest;
    assign out_reg_write = r_main.reg_write;
    assign out_is_lui    = r_main.is_lui;
    assign out_illegal   = r_main.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage with
// hand-computed expectations; honours DECODE_ILLEGAL_TRAP_EN.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [5:0]  out_funct;
    logic [15:0] out_imm16;
    logic [31:0] out_imm_ext;
    logic [25:0] out_jtarget;
    logic [4:0]  out_dest;
    logic        out_reg_write;
    logic        out_is_lui;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    decode_stage #(.PC_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_opcode    (out_opcode),
        .out_rs        (out_rs),
        .out_rt        (out_rt),
        .out_rd        (out_rd),
        .out_shamt     (out_shamt),
        .out_funct     (out_funct),
        .out_imm16     (out_imm16),
        .out_imm_ext   (out_imm_ext),
        .out_jtarget   (out_jtarget),
        .out_dest      (out_dest),
        .out_reg_write (out_reg_write),
        .out_is_lui    (out_is_lui),
        .out_illegal   (out_illegal)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one word for a single cycle, then drop in_valid.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        out_ready = 1'b1;
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
        checkOutput("rst_out_pc", out_pc, 32'h0);
        checkOutput("rst_imm_ext", out_imm_ext, 32'h0);
        checkOutput("rst_opcode", 32'(out_opcode), 32'h0);
        rst = 1'b0;
        tick();

        $display("[TB] single-word decodes");
        applyStimulus(32'h3C081234, 32'h00000040);
        checkOutput("lui_valid", 32'(out_valid), 32'h1);
        checkOutput("lui_pc", out_pc, 32'h40);
        checkOutput("lui_is_lui", 32'(out_is_lui), 32'h1);
        checkOutput("lui_imm16", 32'(out_imm16), 32'h1234);
        checkOutput("lui_imm_ext", out_imm_ext, 32'h12340000);
        checkOutput("lui_dest", 32'(out_dest), 32'd8);
        checkOutput("lui_reg_write", 32'(out_reg_write), 32'h1);

        applyStimulus(32'h2009FFFF, 32'h00000044);
        checkOutput("addi_imm_ext", out_imm_ext, 32'hFFFFFFFF);
        checkOutput("addi_dest", 32'(out_dest), 32'd9);
        checkOutput("addi_is_lui", 32'(out_is_lui), 32'h0);

        applyStimulus(32'h3409FFFF, 32'h00000048);
        checkOutput("ori_imm_ext", out_imm_ext, 32'h0000FFFF);
        checkOutput("ori_opcode", 32'(out_opcode), 32'h0D);

        applyStimulus(32'h012A4020, 32'h0000004C);
        checkOutput("add_dest", 32'(out_dest), 32'd8);
        checkOutput("add_funct", 32'(out_funct), 32'h20);
        checkOutput("add_rs", 32'(out_rs), 32'd9);
        checkOutput("add_rt", 32'(out_rt), 32'd10);
        checkOutput("add_imm_ext", out_imm_ext, 32'h0);
        checkOutput("add_reg_write", 32'(out_reg_write), 32'h1);

        applyStimulus(32'h0C000010, 32'h00000050);
        checkOutput("jal_dest", 32'(out_dest), 32'd31);
        checkOutput("jal_jtarget", 32'(out_jtarget), 32'h10);
        checkOutput("jal_reg_write", 32'(out_reg_write), 32'h1);
        checkOutput("jal_imm_ext", out_imm_ext, 32'h0);

        applyStimulus(32'h20000005, 32'h00000054);
        checkOutput("addi_r0_dest", 32'(out_dest), 32'd0);
        checkOutput("addi_r0_reg_write", 32'(out_reg_write), 32'h0);

        applyStimulus(32'hAD090004, 32'h00000058);
        checkOutput("sw_imm_ext", out_imm_ext, 32'h4);
        checkOutput("sw_reg_write", 32'(out_reg_write), 32'h0);
        checkOutput("sw_dest", 32'(out_dest), 32'd0);

        applyStimulus(32'h1109FFFE, 32'h0000005C);
        checkOutput("beq_imm_ext", out_imm_ext, 32'hFFFFFFFE);
        checkOutput("beq_reg_write", 32'(out_reg_write), 32'h0);

        applyStimulus(32'hFC050000, 32'h00000060);
        checkOutput("bad_op_valid", 32'(out_valid), 32'h1);
        checkOutput("bad_op_reg_write", 32'(out_reg_write), 32'h0);
        checkOutput("bad_op_dest", 32'(out_dest), 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        checkOutput("bad_op_illegal", 32'(out_illegal), 32'h1);
`else
        checkOutput("bad_op_illegal", 32'(out_illegal), 32'h0);
        checkOutput("bad_op_imm_ext", out_imm_ext, 32'h0);
`endif
        tick();
        checkOutput("drained_valid", 32'(out_valid), 32'h0);

        $display("[TB] back-pressure stream");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h20010001;
        in_pc     = 32'h100;
        tick();
        checkOutput("bp1_valid", 32'(out_valid), 32'h1);
        checkOutput("bp1_pc", out_pc, 32'h100);
        checkOutput("bp1_in_ready", 32'(in_ready), 32'h1);
        in_instr = 32'h20020002;
        in_pc    = 32'h104;
        tick();
        checkOutput("bp2_pc", out_pc, 32'h100);
        checkOutput("bp2_rt", 32'(out_rt), 32'd1);
        checkOutput("bp2_in_ready", 32'(in_ready), 32'h0);
        in_instr = 32'h20030003;
        in_pc    = 32'h108;
        tick();
        checkOutput("bp3_pc", out_pc, 32'h100);
        checkOutput("bp3_imm_ext", out_imm_ext, 32'h1);
        checkOutput("bp3_in_ready", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        tick();
        checkOutput("bp4_pc", out_pc, 32'h104);
        checkOutput("bp4_rt", 32'(out_rt), 32'd2);
        checkOutput("bp4_in_ready", 32'(in_ready), 32'h1);
        tick();
        checkOutput("bp5_pc", out_pc, 32'h108);
        checkOutput("bp5_rt", 32'(out_rt), 32'd3);
        in_instr = 32'h20040004;
        in_pc    = 32'h10C;
        tick();
        checkOutput("bp6_pc", out_pc, 32'h10C);
        checkOutput("bp6_rt", 32'(out_rt), 32'd4);
        in_valid = 1'b0;
        tick();
        checkOutput("bp7_valid", 32'(out_valid), 32'h0);

        $display("[TB] flush with both entries full");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h20050005;
        in_pc     = 32'h200;
        tick();
        in_instr = 32'h20060006;
        in_pc    = 32'h204;
        tick();
        checkOutput("fl_pre_in_ready", 32'(in_ready), 32'h0);
        in_instr = 32'h20070007;
        in_pc    = 32'h208;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("fl_out_valid", 32'(out_valid), 32'h0);
        checkOutput("fl_in_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        tick();
        tick();
        checkOutput("fl_stays_empty", 32'(out_valid), 32'h0);

        $display("[TB] flush drops same-cycle input transfer");
        in_valid = 1'b1;
        in_instr = 32'h20080008;
        in_pc    = 32'h300;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("fl_in_dropped", 32'(out_valid), 32'h0);
        applyStimulus(32'h20090009, 32'h304);
        checkOutput("post_flush_valid", 32'(out_valid), 32'h1);
        checkOutput("post_flush_pc", out_pc, 32'h304);
        tick();
        checkOutput("post_flush_drain", 32'(out_valid), 32'h0);

        $display("[TB] reset mid-stream");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h200A000A;
        in_pc     = 32'h400;
        tick();
        in_instr = 32'h200B000B;
        in_pc    = 32'h404;
        tick();
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(out_valid), 32'h0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'h1);
        checkOutput("mid_rst_pc", out_pc, 32'h0);
        in_valid = 1'b0;
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        checkOutput("post_rst_empty", 32'(out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined instruction-decode stage between fetch and the execute-side handlers (LUI, ALU, load/store, branch units).
- Accepts 32-bit MIPS instruction words with a valid/ready handshake.
- Splits each word into fields and extends the immediate. The raw 16-bit immediate goes straight to the LUI handler, whose input is a 16-bit immediate.
- A 2-entry skid buffer gives a registered in_ready and full throughput.

Parameters:
- PC_W, 32, width of the program-counter tag carried with each instruction.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  discard all buffered instructions (branch redirect)
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept; registered
- in_instr  input  32  instruction word
- in_pc  input  PC_W  PC of in_instr
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  downstream accepts
- out_pc  output  PC_W  PC tag
- out_opcode  output  6  instr[31:26]
- out_rs, out_rt, out_rd  output  5 each  instr[25:21], [20:16], [15:11]
- out_shamt  output  5  instr[10:6]
- out_funct  output  6  instr[5:0]
- out_imm16  output  16  instr[15:0], raw; feeds the LUI handler
- out_imm_ext  output  32  extended immediate
- out_jtarget  output  26  instr[25:0]
- out_dest  output  5  destination register
- out_reg_write  output  1  instruction writes the register file
- out_is_lui  output  1  opcode == 6'h0F
- out_illegal  output  1  unrecognised opcode (only with feature)

Behaviour:
- Decode is combinational on the incoming word. Results are stored in the buffer as a decoded bundle.
- Supported opcodes: 00 R-type, 02 J, 03 JAL, 04 BEQ, 05 BNE, 08 ADDI, 09 ADDIU, 0A SLTI, 0C ANDI, 0D ORI, 0E XORI, 0F LUI, 23 LW, 2B SW.
- Immediate extension:
  - Zero-extend for 0C/0D/0E.
  - Sign-extend for 04/05/08/09/0A/23/2B.
  - For 0F, out_imm_ext = {imm16,16'h0000}. This must equal the LUI handler's result.
  - For R-type and J-type, out_imm_ext = 0.
- Destination register:
  - R-type: rd.
  - JAL: 5'd31.
  - 08/09/0A/0C/0D/0E/0F/23: rt.
  - All others: 0.
- out_reg_write is 1 exactly when the instruction is R-type, JAL, or one of 08/09/0A/0C/0D/0E/0F/23, and out_dest != 0. Writes to $zero are suppressed.
- Buffer structure:
  - Main register holds the bundle presented on out_*.
  - Skid register holds one overflow bundle.
  - in_ready = !skid_valid, registered.
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Latency: one cycle, input transfer to out_valid. Throughput is one per cycle while out_ready stays high.
- When out_ready is low and main is full, an accepted word goes to skid and in_ready drops next cycle.
- When the output transfer fires and skid is full, skid moves to main the same edge.
- Simultaneous input and output transfers with an empty skid: the new word goes straight to main.
- Ordering is strictly preserved.
- out_* hold stable while out_valid && !out_ready.
- flush: main and skid are cleared on the next edge and any same-cycle input transfer is dropped. in_ready is 1 the following cycle. flush has priority over everything.
- Reset: out_valid=0, skid empty, in_ready=1, all out_* data=0. Reset asserted mid-transfer drops all buffered words.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - out_illegal=1 for any opcode outside the supported list.
  - out_reg_write forced to 0 for such words.
  - The word still passes through the pipeline.
- Undefined:
  - out_illegal tied 0.
  - Unrecognised opcodes decode with reg_write=0 and imm_ext=0.

Decomposition:
- Shared package mips_pkg:
  - Opcode localparams (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW).
  - REG_RA = 5'd31.
  - Packed struct decoded_t with all out_* data fields.
- One sub-module, instr_field_decoder: purely combinational instr -> decoded_t. It is instantiated once, ahead of the skid-buffer register logic.

Test Plan:
- LUI 32'h3C081234, out_ready=1 -> next cycle: out_is_lui=1, out_imm16=16'h1234, out_imm_ext=32'h12340000, out_dest=8, out_reg_write=1.
- ADDI 32'h2009FFFF -> out_imm_ext=32'hFFFFFFFF, out_dest=9. ORI 32'h3409FFFF -> out_imm_ext=32'h0000FFFF.
- R-type add 32'h012A4020 -> out_dest=8, out_funct=6'h20. JAL 32'h0C000010 -> out_dest=31, out_jtarget=26'h10, out_reg_write=1.
- Back-pressure: stream 4 words, out_ready=0 for 3 cycles. Required:
  - in_ready drops after the second acceptance.
  - No word is lost or duplicated.
  - Output order matches input.
  - out_* stable while stalled.
- flush with both entries full and in_valid=1 -> out_valid=0 next cycle, in_ready=1, and the flushed words never appear. Reset mid-stream gives the same result.
- With DECODE_ILLEGAL_TRAP_EN, opcode 6'h3F targeting rt=5 -> out_illegal=1, out_reg_write=0. Without the macro, out_illegal=0.
